// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the debounced key outputs seen by the consumer.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       key_valid;
   logic       key_press;
   logic       multi;

   modport master (
      input  row,
      output col, key, key_valid, key_press, multi
   );

   modport slave (
      output row,
      input  col, key, key_valid, key_press, multi
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with whole-scan debounce; press strobe lands on the scan-end clock.
// Latency press->key_press <= (DEBOUNCE_SCANS+1) scans + 3 clocks; no backpressure, outputs are levels/strobes.
module keypad_scanner #(
   parameter int SETTLE_CYCLES  = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic              clk,
   input  logic              rst,
   keypad_scanner_if.master  kp
);

   localparam int CW = $clog2(SETTLE_CYCLES);
   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {CLS_NONE, CLS_KEY, CLS_MULTI} cls_t;

   typedef struct packed {
      cls_t       cls;
      logic [3:0] code;
   } scan_res_t;

   // Accumulator bit index is {column, row}.
   function automatic logic [3:0] key_code(input logic [3:0] idx);
      logic [3:0] c;
      case (idx)
         4'd0:  c = 4'h1;
         4'd1:  c = 4'h4;
         4'd2:  c = 4'h7;
         4'd3:  c = 4'h0;
         4'd4:  c = 4'h2;
         4'd5:  c = 4'h5;
         4'd6:  c = 4'h8;
         4'd7:  c = 4'hF;
         4'd8:  c = 4'h3;
         4'd9:  c = 4'h6;
         4'd10: c = 4'h9;
         4'd11: c = 4'hE;
         4'd12: c = 4'hA;
         4'd13: c = 4'hB;
         4'd14: c = 4'hC;
         default: c = 4'hD;
      endcase
      return c;
   endfunction

   logic [3:0]    rows_m, rows_s;
   logic [CW-1:0] settle_cnt;
   logic [1:0]    col_idx;
   logic [15:0]   acc;
   scan_res_t     hist;
   logic [SW-1:0] stable_cnt;

   logic [3:0]    col_r, key_r;
   logic          key_valid_r, key_press_r, multi_r;

   logic          sample;
   logic [15:0]   acc_next;
   logic [4:0]    n_pressed;
   scan_res_t     res;
   logic          same;
   logic [SW-1:0] stable_next;
   logic          accept;

   always_comb begin
      sample   = (settle_cnt == CW'(SETTLE_CYCLES - 1));
      acc_next = acc;
      acc_next[{col_idx, 2'b00} +: 4] = ~rows_s;

      n_pressed = '0;
      res.cls   = CLS_NONE;
      res.code  = 4'h0;
      for (int i = 0; i < 16; i++) begin
         n_pressed = n_pressed + {4'b0, acc_next[i]};
      end
      if (n_pressed == 5'd1) begin
         res.cls = CLS_KEY;
         for (int i = 0; i < 16; i++) begin
            if (acc_next[i]) res.code = key_code(4'(i));
         end
      end else if (n_pressed != 5'd0) begin
         res.cls = CLS_MULTI;
      end

      same = (res == hist);
      if (!same)
         stable_next = SW'(1);
      else if (stable_cnt == SW'(DEBOUNCE_SCANS))
         stable_next = stable_cnt;
      else
         stable_next = stable_cnt + SW'(1);

      // Fire only on the scan that first reaches the threshold, not while saturated.
      accept = (stable_next == SW'(DEBOUNCE_SCANS)) &&
               (!same || stable_cnt != SW'(DEBOUNCE_SCANS));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rows_m      <= 4'hF;
         rows_s      <= 4'hF;
         settle_cnt  <= '0;
         col_idx     <= 2'd0;
         acc         <= '0;
         hist        <= '{cls: CLS_NONE, code: 4'h0};
         stable_cnt  <= '0;
         col_r       <= 4'b1110;
         key_r       <= 4'h0;
         key_valid_r <= 1'b0;
         key_press_r <= 1'b0;
         multi_r     <= 1'b0;
      end else begin
         rows_m      <= kp.row;
         rows_s      <= rows_m;
         key_press_r <= 1'b0;

         if (sample) begin
            acc        <= acc_next;
            settle_cnt <= '0;
            col_idx    <= col_idx + 2'd1;
            col_r      <= ~(4'b0001 << (col_idx + 2'd1));

            if (col_idx == 2'd3) begin
               hist       <= res;
               stable_cnt <= stable_next;
               if (accept) begin
                  case (res.cls)
                     CLS_KEY: begin
                        if (!(key_valid_r && key_r == res.code)) begin
                           key_r       <= res.code;
                           key_valid_r <= 1'b1;
                           multi_r     <= 1'b0;
                           key_press_r <= 1'b1;
                        end
                     end
                     CLS_MULTI: begin
                        multi_r     <= 1'b1;
                        key_valid_r <= 1'b0;
                     end
                     default: begin
                        key_valid_r <= 1'b0;
                        multi_r     <= 1'b0;
                     end
                  endcase
               end
            end
         end else begin
            settle_cnt <= settle_cnt + CW'(1);
         end
      end
   end

   assign kp.col       = col_r;
   assign kp.key       = key_r;
   assign kp.key_valid = key_valid_r;
   assign kp.key_press = key_press_r;
   assign kp.multi     = multi_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: behavioural keypad matrix, press-code scoreboard and table-driven key steps.
module tb_keypad_scanner;
   localparam int SETTLE = 4;
   localparam int DEB    = 2;
   localparam int SCAN   = 4 * SETTLE;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] held;
   logic [3:0]  row_model;

   int checks    = 0;
   int failures  = 0;
   int press_cnt = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic [15:0] held;
      logic [3:0]  key;
      logic        valid;
      logic        multi;
      logic        press;
   } vec_t;
   vec_t tbl[10];

   keypad_scanner_if kif();

   keypad_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kif)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a held key at {col c,row r} pulls row r low while col c is driven low.
   always_comb begin
      row_model = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!kif.col[c] && held[4*c+r]) row_model[r] = 1'b0;
   end
   assign kif.row = row_model;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every key_press pops the code queued when the stimulus was applied.
   always @(negedge clk) begin
      if (rst === 1'b0 && kif.key_press === 1'b1) begin
         press_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_press actual_key=%0h expected=no_press at %0t", kif.key, $time);
         end else begin
            check("press_code", {28'b0, kif.key}, {28'b0, exp_q.pop_front()});
         end
      end
   end

   // Align to the negedge just after column 0 becomes active (scan boundary).
   task automatic sync_scan();
      int n = 0;
      while (kif.col !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
      while (kif.col !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
      check("scan_sync_in_time", {31'b0, n < 40}, 32'd1);
   endtask

   initial begin
      int p0, bad, n;

      tbl[0] = '{16'h0000, 4'h5, 1'b0, 1'b0, 1'b0};  // release from 5
      tbl[1] = '{16'h8000, 4'hD, 1'b1, 1'b0, 1'b1};  // D
      tbl[2] = '{16'h0000, 4'hD, 1'b0, 1'b0, 1'b0};  // release
      tbl[3] = '{16'h8000, 4'hD, 1'b1, 1'b0, 1'b1};  // re-press D
      tbl[4] = '{16'h0011, 4'hD, 1'b0, 1'b1, 1'b0};  // 1+2 together
      tbl[5] = '{16'h0010, 4'h2, 1'b1, 1'b0, 1'b1};  // 2 only
      tbl[6] = '{16'h0100, 4'h3, 1'b1, 1'b0, 1'b1};  // roll to 3
      tbl[7] = '{16'h1000, 4'hA, 1'b1, 1'b0, 1'b1};  // roll to A
      tbl[8] = '{16'h0080, 4'hF, 1'b1, 1'b0, 1'b1};  // F
      tbl[9] = '{16'h0008, 4'h0, 1'b1, 1'b0, 1'b1};  // 0

      // Reset state and column walk
      rst  = 1'b1;
      held = 16'h0;
      repeat (3) @(negedge clk);
      check("rst_col", {28'b0, kif.col}, 32'he);
      check("rst_key", {28'b0, kif.key}, 32'h0);
      check("rst_valid", {31'b0, kif.key_valid}, 32'd0);
      check("rst_press", {31'b0, kif.key_press}, 32'd0);
      check("rst_multi", {31'b0, kif.multi}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("walk_k3", {28'b0, kif.col}, 32'he);
      @(negedge clk);
      check("walk_k4", {28'b0, kif.col}, 32'hd);
      repeat (4) @(negedge clk);
      check("walk_k8", {28'b0, kif.col}, 32'hb);
      repeat (4) @(negedge clk);
      check("walk_k12", {28'b0, kif.col}, 32'h7);
      repeat (4) @(negedge clk);
      check("walk_k16", {28'b0, kif.col}, 32'he);

      // Bounce: '5' only on alternate scans
      sync_scan();
      bad = 0;
      for (int s = 0; s < 8; s++) begin
         held = (s % 2 == 0) ? 16'h0020 : 16'h0000;
         repeat (SCAN) begin
            @(negedge clk);
            if (kif.key_press || kif.key_valid) bad++;
         end
      end
      check("bounce_no_accept", bad, 0);

      // Hold '5': one pulse within the latency bound, none while held
      held = 16'h0020;
      exp_q.push_back(4'h5);
      p0 = press_cnt;
      n  = 0;
      while (kif.key_press !== 1'b1 && n < (DEB + 1) * SCAN + 3) begin
         @(negedge clk);
         n++;
      end
      check("press5_in_time", {31'b0, kif.key_press}, 32'd1);
      sync_scan();
      repeat (10 * SCAN) @(negedge clk);
      check("press5_once", press_cnt - p0, 1);
      check("hold5_key", {28'b0, kif.key}, 32'h5);
      check("hold5_valid", {31'b0, kif.key_valid}, 32'd1);

      // Table-driven key sequence
      for (int i = 0; i < 10; i++) begin
         held = tbl[i].held;
         if (tbl[i].press) exp_q.push_back(tbl[i].key);
         p0 = press_cnt;
         repeat (4 * SCAN) @(negedge clk);
         check($sformatf("step%0d_key", i), {28'b0, kif.key}, {28'b0, tbl[i].key});
         check($sformatf("step%0d_valid", i), {31'b0, kif.key_valid}, {31'b0, tbl[i].valid});
         check($sformatf("step%0d_multi", i), {31'b0, kif.multi}, {31'b0, tbl[i].multi});
         check($sformatf("step%0d_presses", i), press_cnt - p0, {31'b0, tbl[i].press});
      end

      // Reset in the middle of a column window while a key is accepted
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_valid", {31'b0, kif.key_valid}, 32'd0);
      check("midrst_key", {28'b0, kif.key}, 32'h0);
      check("midrst_col", {28'b0, kif.col}, 32'he);
      check("midrst_multi", {31'b0, kif.multi}, 32'd0);
      held = 16'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("restart_k3", {28'b0, kif.col}, 32'he);
      @(negedge clk);
      check("restart_k4", {28'b0, kif.col}, 32'hd);
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
